wu_fetch: RTL and testbench
===========================

# wu_fetch

Work-unit instruction fetch engine for the manager. It accepts a fetch request (start address and instruction count) from the manager's WU scheduler and issues sequential read strobes and addresses to the WU instruction memory. It pauses while that memory asserts stall, and signals completion back to the scheduler. It is the initiator side of the `wuf__wum__*` read interface and produces no instruction data itself; fetched data flows from memory straight to WU decode.

## Interface
- No module parameters. All widths come from defines.
- `MGR_WU_ADDRESS_RANGE`: existing define; sets the instruction address width (AW).
- `MGR_WU_FETCH_CNT_RANGE`: new define in `wu_fetch.vh`; sets the instruction-count width (CW). Default `15:0`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_poweron` in 1: **asynchronous, active-low** reset.
- `sys__mgr__mgrId` in `MGR_MGR_ID_RANGE`: manager ID. Debug/trace only; no functional effect.
- `sch__wuf__valid` in 1: fetch request valid.
- `wuf__sch__ready` out 1: fetch request ready.
- `sch__wuf__addr` in AW: start address of the WU.
- `sch__wuf__num_inst` in CW: number of instruction words to fetch.
- `wuf__sch__done` out 1: one-cycle pulse; the last read of the request has been issued.
- `wuf__sch__busy` out 1: request in progress.
- `wuf__wum__addr` out AW: read address to WU memory.
- `wuf__wum__read` out 1: read strobe to WU memory. Each high cycle is exactly one read.
- `wum__wuf__stall` in 1: memory back-pressure. While high, no new reads are issued.

## Operation
- FSM has two states.
  - IDLE: `wuf__sch__ready`=1.
  - FETCH: `wuf__sch__ready`=0.
- Request acceptance:
  - A request is accepted on a rising edge where `sch__wuf__valid` & `wuf__sch__ready`.
  - On acceptance, `cur_addr`<=`sch__wuf__addr` and `remaining`<=`sch__wuf__num_inst`.
- Zero-length request (`num_inst`=0):
  - Accepted normally.
  - `wuf__sch__done` pulses on the following cycle.
  - No read is issued and the FSM stays in IDLE.
- Non-zero request: the FSM goes IDLE->FETCH.
- Each edge in FETCH:
  - If `wum__wuf__stall`=0:
    - `wuf__wum__read`<=1 and `wuf__wum__addr`<=`cur_addr`.
    - `cur_addr`<=`cur_addr`+1 and `remaining`<=`remaining`-1.
    - If `remaining`==1: `wuf__sch__done`<=1 and FETCH->IDLE.
  - If `wum__wuf__stall`=1: `wuf__wum__read`<=0, and `cur_addr` and `remaining` hold.
- Address arithmetic:
  - Increments are modulo 2^AW. Address all-ones wraps to 0 silently.
  - Requests longer than the memory depth are legal and simply wrap.
- `wuf__wum__addr` holds its last value when `wuf__wum__read`=0. It is don't-care to the memory.
- `wuf__sch__busy` = (state==FETCH).
- Stall is sampled only in FETCH. A stall seen in IDLE has no effect.
- `sch__wuf__valid` while busy is ignored, because ready=0. The scheduler must hold the request.
- Back-to-back requests:
  - Ready returns on the cycle after the last read is issued.
  - The minimum gap between the last read of request A and the first read of request B is 1 idle cycle.
- Reset mid-operation:
  - Asynchronous clear; `wuf__wum__read` drops immediately.
  - The in-flight request is discarded with no done pulse.
  - State returns to IDLE.

## Timing
- All outputs are registered except `wuf__sch__ready` and `wuf__sch__busy`, which decode directly from the state register.
- Reset values:
  - `wuf__wum__read`=0, `wuf__wum__addr`=0, `wuf__sch__done`=0.
  - State=IDLE, so `wuf__sch__ready`=1 and `wuf__sch__busy`=0.
- Latency:
  - Request accepted at edge k: the first read is high after edge k+1 if stall=0 at edge k+1.
  - Unstalled throughput is one read per cycle.
- N-instruction request with no stall: reads after edges k+1..k+N; done pulse is coincident with the Nth read.
- Stall response:
  - A stall sampled at edge j suppresses the read after edge j.
  - WU memory registers its stall from decode-ready. Reads in its pipeline are its responsibility; fetch only honours stall at its own input.

## Structure
- `wu_fetch.vh` contains:
  - `MGR_WU_FETCH_CNT_RANGE`.
  - State encodings `MGR_WU_FETCH_STATE_IDLE`=1'b0 and `MGR_WU_FETCH_STATE_FETCH`=1'b1.
  - `MGR_WU_FETCH_STATE_RANGE`.
- Include the existing `manager.vh` and `wu_memory.vh` for address and ID ranges.
- Single flat module; no sub-module. Request capture, counter and FSM total roughly 150 lines.

## Test plan
- Reset then idle: ready=1, read=0, addr=0, done=0. Assert valid with addr=0x10, num=4 and no stall -> reads at 0x10, 0x11, 0x12, 0x13 on consecutive cycles; done coincident with the 0x13 read; ready back the next cycle.
- Zero length: addr=0x20, num=0 -> no read; one done pulse one cycle after acceptance; busy never asserted.
- Stall: num=5 from 0x00, stall high for 3 cycles after the second read -> reads 0x00, 0x01, gap of 3, then 0x02, 0x03, 0x04; no address skipped or repeated; exactly 5 read cycles.
- Wrap-around: addr=all-ones-1, num=4 -> reads all-ones-1, all-ones, 0, 1; done with the read at 1.
- Busy-collision and back-to-back: a second valid held during request A is not accepted until ready. Request B is accepted the cycle after A's done, and B's first read follows 1 idle cycle later.
- Async reset mid-request: reset asserted during the third of 8 reads -> read drops without waiting for a clock; no done pulse; after release ready=1 and a new request fetches from its own start address.

Source files
------------

// File: rtl/wu_fetch_pkg.sv
// rtl/wu_fetch_pkg.sv - widths, FSM encoding and address helper for the WU fetch engine
package wu_fetch_pkg;

  localparam int WU_ADDR_W      = 16;
  localparam int WU_FETCH_CNT_W = 16;
  localparam int MGR_ID_W       = 8;

  typedef enum logic {
    WUF_IDLE  = 1'b0,
    WUF_FETCH = 1'b1
  } wu_fetch_state_e;

  // Instruction addresses wrap silently at the top of memory.
  function automatic logic [WU_ADDR_W-1:0] wu_addr_next(input logic [WU_ADDR_W-1:0] addr);
    return addr + WU_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/wu_fetch_if.sv
// rtl/wu_fetch_if.sv - scheduler request/done and WU memory read signals of the fetch engine
interface wu_fetch_if;
  import wu_fetch_pkg::*;

  logic                      sch__wuf__valid;
  logic                      wuf__sch__ready;
  logic [WU_ADDR_W-1:0]      sch__wuf__addr;
  logic [WU_FETCH_CNT_W-1:0] sch__wuf__num_inst;
  logic                      wuf__sch__done;
  logic                      wuf__sch__busy;
  logic [WU_ADDR_W-1:0]      wuf__wum__addr;
  logic                      wuf__wum__read;
  logic                      wum__wuf__stall;

  // slave: the fetch engine; master: scheduler plus WU memory around it
  modport slave (
    input  sch__wuf__valid, sch__wuf__addr, sch__wuf__num_inst, wum__wuf__stall,
    output wuf__sch__ready, wuf__sch__done, wuf__sch__busy, wuf__wum__addr, wuf__wum__read
  );

  modport master (
    output sch__wuf__valid, sch__wuf__addr, sch__wuf__num_inst, wum__wuf__stall,
    input  wuf__sch__ready, wuf__sch__done, wuf__sch__busy, wuf__wum__addr, wuf__wum__read
  );

endinterface

// File: rtl/wu_fetch.sv
// rtl/wu_fetch.sv - issues sequential WU memory reads for a scheduler fetch request
module wu_fetch
  import wu_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                reset_poweron,
  input  logic [MGR_ID_W-1:0] sys__mgr__mgrId,
  wu_fetch_if.slave           bus
);

  wu_fetch_state_e           state_q, state_d;
  logic [WU_ADDR_W-1:0]      cur_addr_q, cur_addr_d;
  logic [WU_ADDR_W-1:0]      rd_addr_q, rd_addr_d;
  logic [WU_FETCH_CNT_W-1:0] remaining_q, remaining_d;
  logic                      read_q, read_d;
  logic                      done_q, done_d;

  // Manager ID is trace-only context and has no functional effect.
  logic unused_mgr_id;
  assign unused_mgr_id = ^sys__mgr__mgrId;

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_q     <= WUF_IDLE;
      cur_addr_q  <= '0;
      rd_addr_q   <= '0;
      remaining_q <= '0;
      read_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      rd_addr_q   <= rd_addr_d;
      remaining_q <= remaining_d;
      read_q      <= read_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    rd_addr_d   = rd_addr_q;
    remaining_d = remaining_q;
    read_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      WUF_IDLE: begin
        if (bus.sch__wuf__valid) begin
          cur_addr_d  = bus.sch__wuf__addr;
          remaining_d = bus.sch__wuf__num_inst;
          // A zero-length request completes without ever leaving IDLE.
          if (bus.sch__wuf__num_inst == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = WUF_FETCH;
          end
        end
      end
      WUF_FETCH: begin
        if (!bus.wum__wuf__stall) begin
          read_d      = 1'b1;
          rd_addr_d   = cur_addr_q;
          cur_addr_d  = wu_addr_next(cur_addr_q);
          remaining_d = remaining_q - WU_FETCH_CNT_W'(1);
          if (remaining_q == WU_FETCH_CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = WUF_IDLE;
          end
        end
      end
      default: state_d = WUF_IDLE;
    endcase
  end

  assign bus.wuf__sch__ready = (state_q == WUF_IDLE);
  assign bus.wuf__sch__busy  = (state_q == WUF_FETCH);
  assign bus.wuf__sch__done  = done_q;
  assign bus.wuf__wum__read  = read_q;
  assign bus.wuf__wum__addr  = rd_addr_q;

endmodule

// File: tb/tb_wu_fetch.sv
// tb/tb_wu_fetch.sv - directed and random fetch requests against a queue-based reference model
module tb_wu_fetch;
  import wu_fetch_pkg::*;

  logic clk = 1'b0;
  logic reset_poweron;
  logic [MGR_ID_W-1:0] mgr_id = 8'h5A;

  wu_fetch_if bus();

  wu_fetch dut (
    .clk             (clk),
    .reset_poweron   (reset_poweron),
    .sys__mgr__mgrId (mgr_id),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending read addresses of the active request.
  logic [WU_ADDR_W-1:0] m_q[$];
  logic                 m_busy = 1'b0;
  logic                 m_read = 1'b0;
  logic                 m_done = 1'b0;
  logic [WU_ADDR_W-1:0] m_addr = '0;
  logic                 m_acc  = 1'b0;
  int                   exp_reads = 0;
  int                   obs_reads = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_edge(input logic v, input logic [WU_ADDR_W-1:0] a,
                          input logic [WU_FETCH_CNT_W-1:0] n, input logic s);
    m_acc  = 1'b0;
    m_read = 1'b0;
    m_done = 1'b0;
    if (!m_busy) begin
      if (v) begin
        m_acc = 1'b1;
        for (int i = 0; i < int'(n); i++) m_q.push_back(a + WU_ADDR_W'(i));
        exp_reads += int'(n);
        if (n == '0) m_done = 1'b1;
        else         m_busy = 1'b1;
      end
    end else if (!s) begin
      m_read = 1'b1;
      m_addr = m_q.pop_front();
      if (m_q.size() == 0) begin
        m_done = 1'b1;
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic mdl_reset();
    exp_reads -= m_q.size();
    m_q.delete();
    m_busy = 1'b0;
    m_read = 1'b0;
    m_done = 1'b0;
    m_addr = '0;
  endtask

  task automatic check_outputs();
    chk("read",  32'(bus.wuf__wum__read), 32'(m_read));
    chk("addr",  32'(bus.wuf__wum__addr), 32'(m_addr));
    chk("done",  32'(bus.wuf__sch__done), 32'(m_done));
    chk("ready", 32'(bus.wuf__sch__ready), 32'(!m_busy));
    chk("busy",  32'(bus.wuf__sch__busy), 32'(m_busy));
    if (bus.wuf__wum__read === 1'b1) obs_reads++;
  endtask

  task automatic step(input logic v, input logic [WU_ADDR_W-1:0] a,
                      input logic [WU_FETCH_CNT_W-1:0] n, input logic s);
    bus.sch__wuf__valid    = v;
    bus.sch__wuf__addr     = a;
    bus.sch__wuf__num_inst = n;
    bus.wum__wuf__stall    = s;
    @(posedge clk);
    mdl_edge(v, a, n, s);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int cycles, input logic s);
    for (int i = 0; i < cycles; i++) step(1'b0, '0, '0, s);
  endtask

  initial begin
    reset_poweron          = 1'b0;
    bus.sch__wuf__valid    = 1'b0;
    bus.sch__wuf__addr     = '0;
    bus.sch__wuf__num_inst = '0;
    bus.wum__wuf__stall    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    #2 reset_poweron = 1'b1;

    // Basic four-word fetch, no stall
    step(1'b1, 16'h0010, 16'd4, 1'b0);
    idle(5, 1'b0);
    chk("count_basic", 32'(obs_reads), 32'(exp_reads));

    // Zero length: done only, never busy; stall in idle is ignored
    step(1'b1, 16'h0020, 16'd0, 1'b1);
    idle(2, 1'b1);
    chk("count_zero", 32'(obs_reads), 32'(exp_reads));

    // Stall for three cycles after the second read
    step(1'b1, 16'h0000, 16'd5, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);
    idle(4, 1'b0);
    chk("count_stall", 32'(obs_reads), 32'(exp_reads));

    // Address wrap past all-ones
    step(1'b1, 16'hFFFE, 16'd4, 1'b0);
    idle(5, 1'b0);
    chk("count_wrap", 32'(obs_reads), 32'(exp_reads));

    // Request B held valid while A is busy, accepted right after A's done
    step(1'b1, 16'h0040, 16'd3, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 16'h0080, 16'd2, 1'b0);
    idle(2, 1'b0);
    chk("count_b2b", 32'(obs_reads), 32'(exp_reads));

    // Asynchronous reset during the third of eight reads
    step(1'b1, 16'h0100, 16'd8, 1'b0);
    idle(3, 1'b0);
    #3 reset_poweron = 1'b0;
    mdl_reset();
    #1;
    check_outputs();
    #2 reset_poweron = 1'b1;
    step(1'b1, 16'h0200, 16'd3, 1'b0);
    idle(4, 1'b0);
    chk("count_reset", 32'(obs_reads), 32'(exp_reads));

    // Random requests with random stall and gaps
    for (int r = 0; r < 40; r++) begin
      logic [WU_ADDR_W-1:0]      ra;
      logic [WU_FETCH_CNT_W-1:0] rn;
      int                        tries;
      idle($urandom_range(0, 2), 1'($urandom_range(0, 1)));
      ra = WU_ADDR_W'($urandom);
      rn = WU_FETCH_CNT_W'($urandom_range(0, 6));
      tries = 0;
      do begin
        step(1'b1, ra, rn, ($urandom_range(0, 3) == 0));
        tries++;
      end while (!m_acc && tries < 20);
      n_vec++;
      assert (m_acc) else begin
        n_err++;
        $error("FAIL accept_timeout observed=%0d expected=%0d", m_acc, 1);
      end
      tries = 0;
      while (m_busy && tries < 60) begin
        step(1'b0, '0, '0, ($urandom_range(0, 3) == 0));
        tries++;
      end
      n_vec++;
      assert (!m_busy) else begin
        n_err++;
        $error("FAIL drain_timeout observed=%0d expected=%0d", m_busy, 0);
      end
    end
    idle(2, 1'b0);
    chk("count_random", 32'(obs_reads), 32'(exp_reads));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
